// File: rtl/cmd_router_if.sv
// Host-stream and channel-side signals of cmd_router.
// slave is the router's view; master is the host/sink view.
interface cmd_router_if #(
    parameter int N_CH = 8,
    parameter int DW   = 8
);
    logic [DW-1:0]   rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [DW-1:0]   q;
    logic            q_last;
    logic [N_CH-1:0] valid_bus;
    logic [N_CH-1:0] out_ready;
    logic            crc_err;
    logic            dest_err;
    logic            timeout_err;
    logic [15:0]     err_cnt;

    modport slave (
        input  rx_data, rx_valid, out_ready,
        output rx_ready, q, q_last, valid_bus, crc_err, dest_err, timeout_err, err_cnt
    );

    modport master (
        output rx_data, rx_valid, out_ready,
        input  rx_ready, q, q_last, valid_bus, crc_err, dest_err, timeout_err, err_cnt
    );
endinterface

// File: rtl/cmd_router.sv
// Framed command parser: PREFIX DEST LEN payload CRC. Buffers the payload and
// forwards only fully validated packets to one of N_CH channels.
module cmd_router #(
    parameter int            N_CH        = 8,
    parameter int            DW          = 8,
    parameter int            DEPTH       = 256,
    parameter logic [DW-1:0] PREFIX      = 8'hAA,
    parameter bit            CRC_EN      = 1'b1,
    parameter int            TIMEOUT_CYC = 100000
) (
    input logic          clk,
    input logic          n_rst,
    cmd_router_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_DEST, S_LEN, S_DATA, S_CRC, S_FWD} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   dest, len, crc;
    logic [PW-1:0]   ptr;
    logic [TW-1:0]   tcnt;
    logic [DW-1:0]   mem [DEPTH];
    logic            crc_err_r, dest_err_r, tmo_r;
    logic [15:0]     err_cnt_r;

    logic            acc, in_frame, tmo, hs, ptr_last, crc_bad, dest_bad;
    logic            ev_crc, ev_dest;
    logic [N_CH-1:0] vb;

    assign acc      = bus.rx_valid && (state != S_FWD);
    assign in_frame = (state == S_DEST) || (state == S_LEN) || (state == S_DATA) || (state == S_CRC);
    assign tmo      = in_frame && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign ptr_last = (ptr == PW'(len) - PW'(1));
    assign crc_bad  = CRC_EN && (bus.rx_data != crc);
    assign dest_bad = 32'(dest) >= 32'(N_CH);
    assign vb       = (state == S_FWD) ? (N_CH'(1) << dest) : '0;
    // Only the addressed channel's ready matters; vb masks the others out.
    assign hs       = |(vb & bus.out_ready);

    always_comb begin
        state_n = state;
        ev_crc  = 1'b0;
        ev_dest = 1'b0;
        if (tmo) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (acc && bus.rx_data == PREFIX) state_n = S_DEST;
                S_DEST: if (acc) state_n = S_LEN;
                S_LEN:  if (acc) state_n = (bus.rx_data == '0) ? S_CRC : S_DATA;
                S_DATA: if (acc && ptr_last) state_n = S_CRC;
                S_CRC: begin
                    if (acc) begin
                        if (crc_bad) begin
                            ev_crc  = 1'b1;
                            state_n = S_IDLE;
                        end else if (dest_bad) begin
                            ev_dest = 1'b1;
                            state_n = S_IDLE;
                        end else if (len == '0) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_FWD;
                        end
                    end
                end
                S_FWD:  if (hs && ptr_last) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            dest       <= '0;
            len        <= '0;
            crc        <= '0;
            ptr        <= '0;
            tcnt       <= '0;
            crc_err_r  <= 1'b0;
            dest_err_r <= 1'b0;
            tmo_r      <= 1'b0;
            err_cnt_r  <= '0;
        end else begin
            state      <= state_n;
            crc_err_r  <= ev_crc;
            dest_err_r <= ev_dest;
            tmo_r      <= tmo;
            if ((ev_crc || ev_dest || tmo) && err_cnt_r != 16'hFFFF)
                err_cnt_r <= err_cnt_r + 16'd1;
            tcnt <= (!in_frame || acc || tmo) ? '0 : tcnt + TW'(1);

            // A word arriving in the abort cycle is dropped with the frame.
            if (acc && !tmo) begin
                case (state)
                    S_DEST: begin
                        dest <= bus.rx_data;
                        crc  <= bus.rx_data;
                    end
                    S_LEN: begin
                        len <= bus.rx_data;
                        crc <= crc + bus.rx_data;
                        ptr <= '0;
                    end
                    S_DATA: begin
                        crc <= crc + bus.rx_data;
                        ptr <= ptr + PW'(1);
                    end
                    default: ;
                endcase
            end
            if (state == S_CRC && state_n == S_FWD) ptr <= '0;
            if (hs) ptr <= ptr + PW'(1);
            if (state_n == S_IDLE && state != S_IDLE) ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && acc && !tmo) mem[ptr] <= bus.rx_data;
    end

    assign bus.rx_ready    = (state != S_FWD);
    assign bus.q           = (state == S_FWD) ? mem[ptr] : '0;
    assign bus.q_last      = (state == S_FWD) && ptr_last;
    assign bus.valid_bus   = vb;
    assign bus.crc_err     = crc_err_r;
    assign bus.dest_err    = dest_err_r;
    assign bus.timeout_err = tmo_r;
    assign bus.err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_cmd_router.sv
// Scoreboard bench for cmd_router: randomized frames checked against a
// packet-level reference model; a second instance runs with CRC checking off.
module tb_cmd_router;
    localparam int N_CH = 8;
    localparam int DW   = 8;
    localparam int TO   = 40;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    cmd_router_if #(.N_CH(N_CH), .DW(DW)) bus ();
    cmd_router_if #(.N_CH(N_CH), .DW(DW)) bus_nc ();

    cmd_router #(.N_CH(N_CH), .DW(DW), .DEPTH(256), .PREFIX(8'hAA), .CRC_EN(1'b1), .TIMEOUT_CYC(TO))
        dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    cmd_router #(.N_CH(N_CH), .DW(DW), .DEPTH(256), .PREFIX(8'hAA), .CRC_EN(1'b0), .TIMEOUT_CYC(TO))
        dut_nc (.clk(clk), .n_rst(n_rst), .bus(bus_nc));

    typedef struct packed {
        logic [7:0] dest;
        logic [7:0] data;
        logic       last;
    } word_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    word_t       exp_w[$];
    int          exp_e[$];     // 1 = crc, 2 = dest, 4 = timeout
    int          exp_cnt = 0;
    bit          mon_en  = 1'b0;
    int          rdy_mode = 0; // 0 all ready, 1 random, 2 bit 3 toggling
    logic [16:0] nc_got[$];
    int          nc_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sink-side ready pattern generator
    initial begin
        logic tog;
        logic [7:0] r;
        tog = 1'b0;
        bus.out_ready    = '0;
        bus_nc.out_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            r = 8'($urandom);
            if (rdy_mode == 0) r = '1;
            if (rdy_mode == 2) r[3] = tog;
            tog = ~tog;
            bus.out_ready = r;
        end
    end

    // Main monitor: pops the scoreboard on every handshake or error pulse.
    initial begin
        bit         stall_v;
        logic [7:0] stall_q, stall_vb;
        word_t      w;
        logic [2:0] e;
        stall_v = 1'b0;
        stall_q = '0;
        stall_vb = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("rx_ready_vs_fwd", 32'(bus.rx_ready), 32'(bus.valid_bus == '0));
                if (bus.valid_bus != '0) begin
                    chk("valid_onehot", 32'($onehot(bus.valid_bus)), 32'd1);
                    if (stall_v) begin
                        chk("q_hold", 32'(bus.q), 32'(stall_q));
                        chk("vb_hold", 32'(bus.valid_bus), 32'(stall_vb));
                    end
                    if ((bus.valid_bus & bus.out_ready) != '0) begin
                        stall_v = 1'b0;
                        if (exp_w.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_word: got q=%h vb=%h, none expected", bus.q, bus.valid_bus);
                        end else begin
                            w = exp_w.pop_front();
                            chk("valid_bus", 32'(bus.valid_bus), 32'd1 << w.dest);
                            chk("q", 32'(bus.q), 32'(w.data));
                            chk("q_last", 32'(bus.q_last), 32'(w.last));
                        end
                    end else begin
                        stall_v  = 1'b1;
                        stall_q  = bus.q;
                        stall_vb = bus.valid_bus;
                    end
                end else begin
                    stall_v = 1'b0;
                end
                e = {bus.timeout_err, bus.dest_err, bus.crc_err};
                if (e != '0) begin
                    if (exp_e.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_err: got pulses %b, none expected", e);
                    end else begin
                        chk("err_kind", 32'(e), 32'(exp_e.pop_front()));
                        exp_cnt++;
                        chk("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
                    end
                end
            end
        end
    end

    // Collector for the CRC-disabled instance
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ((bus_nc.valid_bus & bus_nc.out_ready) != '0)
                    nc_got.push_back({bus_nc.valid_bus, bus_nc.q, bus_nc.q_last});
                if (bus_nc.crc_err || bus_nc.dest_err || bus_nc.timeout_err) nc_errs++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input bit which, input logic [7:0] b);
        int w;
        bit ok;
        w  = 0;
        ok = 1'b0;
        if (which) begin
            bus_nc.rx_data = b;
            bus_nc.rx_valid = 1'b1;
        end else begin
            bus.rx_data = b;
            bus.rx_valid = 1'b1;
        end
        while (!ok && w < 3000) begin
            @(negedge clk);
            ok = which ? bus_nc.rx_ready : bus.rx_ready;
            w++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_accept: byte %h not accepted after %0d cycles", b, w);
        end
        @(posedge clk);
        #1;
        if (which) bus_nc.rx_valid = 1'b0;
        else       bus.rx_valid = 1'b0;
    endtask

    // Reference model: a frame's outcome from its fields alone.
    function automatic void expect_pkt(input logic [7:0] d, input logic [7:0] crcb, input logic [7:0] pl[$]);
        int sum;
        word_t w;
        sum = int'(d) + pl.size();
        foreach (pl[i]) sum += int'(pl[i]);
        sum = sum % 256;
        if (int'(crcb) != sum) exp_e.push_back(1);
        else if (int'(d) >= N_CH) exp_e.push_back(2);
        else begin
            foreach (pl[i]) begin
                w.dest = d;
                w.data = pl[i];
                w.last = (i == pl.size() - 1);
                exp_w.push_back(w);
            end
        end
    endfunction

    task automatic run_pkt(input bit which, input logic [7:0] d, input logic [7:0] pl[$],
                           input logic [7:0] crcb, input int gap);
        logic [7:0] bq[$];
        bq.push_back(8'hAA);
        bq.push_back(d);
        bq.push_back(8'(pl.size()));
        foreach (pl[i]) bq.push_back(pl[i]);
        bq.push_back(crcb);
        if (!which) expect_pkt(d, crcb, pl);
        foreach (bq[i]) begin
            send_byte(which, bq[i]);
            if (gap > 0) idle($urandom_range(gap, 0));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_w.size() != 0 || exp_e.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        idle(3);
        if (n >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d words, %0d errors still pending", exp_w.size(), exp_e.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] d, crcb, b;
        int sum, len;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus_nc.rx_valid = 1'b0;
        bus_nc.rx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_valid_bus", 32'(bus.valid_bus), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_q_last", 32'(bus.q_last), 32'd0);
        chk("rst_err_pulses", 32'({bus.crc_err, bus.dest_err, bus.timeout_err}), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(posedge clk);
        #1;
        n_rst  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Good frame, bad CRC, then bad destination
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
        run_pkt(0, 8'h03, pl, 8'h38, 0);
        drain();
        run_pkt(0, 8'h03, pl, 8'h39, 0);
        drain();
        pl.delete(); pl.push_back(8'h55);
        run_pkt(0, 8'h09, pl, 8'h5F, 0);
        drain();

        // CRC checking disabled: the bad-CRC frame goes through
        pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22);
        run_pkt(1, 8'h03, pl, 8'h39, 0);
        idle(10);
        chk("nc_count", 32'(nc_got.size()), 32'd2);
        if (nc_got.size() == 2) begin
            chk("nc_word0", 32'(nc_got[0]), 32'({8'h08, 8'h11, 1'b0}));
            chk("nc_word1", 32'(nc_got[1]), 32'({8'h08, 8'h22, 1'b1}));
        end
        chk("nc_errs", 32'(nc_errs), 32'd0);
        chk("nc_err_cnt", 32'(bus_nc.err_cnt), 32'd0);

        // Stalling sink with the next frame queued behind the forward
        rdy_mode = 2;
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'(8'h40 + i));
        run_pkt(0, 8'h03, pl, 8'(3 + 6 + 8'h40 * 6 + 15), 0);
        run_pkt(0, 8'h03, pl, 8'(3 + 6 + 8'h40 * 6 + 15), 0);
        drain();
        rdy_mode = 0;

        // Timeout mid-frame, then recovery
        exp_e.push_back(4);
        send_byte(0, 8'hAA);
        send_byte(0, 8'h02);
        send_byte(0, 8'h05);
        send_byte(0, 8'h01);
        idle(TO + 5);
        pl.delete(); pl.push_back(8'h7E);
        run_pkt(0, 8'h02, pl, 8'h81, 0);
        drain();

        // Zero-length frame and leading junk
        pl.delete();
        run_pkt(0, 8'h04, pl, 8'h04, 0);
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        pl.push_back(8'h5A);
        run_pkt(0, 8'h01, pl, 8'h5C, 0);
        drain();

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            rdy_mode = $urandom_range(2, 0);
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                b = 8'($urandom);
                if (b == 8'hAA) b = 8'h00;
                send_byte(0, b);
            end
            d   = 8'($urandom_range(10, 0));
            len = $urandom_range(12, 0);
            pl.delete();
            sum = int'(d) + len;
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                sum += int'(pl[i]);
            end
            crcb = 8'(sum);
            if ($urandom_range(5, 0) == 0) crcb = crcb + 8'($urandom_range(255, 1));
            run_pkt(0, d, pl, crcb, 2);
            if ($urandom_range(3, 0) == 0) drain();
        end
        rdy_mode = 0;
        drain();
        chk("words_left", 32'(exp_w.size()), 32'd0);
        chk("errs_left", 32'(exp_e.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_router.md
Name: cmd_router

Overview:
- Parametrised successor to the single-destination command decoder.
- Parses framed command packets from the host byte stream: PREFIX, DEST, LEN, LEN payload words, CRC.
- Buffers the payload and checks CRC and destination. Only fully validated packets are forwarded, to one of N_CH downstream channels, with per-channel backpressure.
- Adds CRC enforcement, destination range checking, input backpressure, a synchronous timeout and error reporting.

Parameters:
- N_CH, 8, number of output channels; DEST values 0..N_CH-1 are legal.
- DW, 8, word width of rx_data, q and CRC.
- DEPTH, 256, payload buffer depth in words; must be >= 2^DW - 1 (maximum LEN).
- PREFIX, 8'hAA, frame start word.
- CRC_EN, 1; 1 = drop packets with a bad CRC, 0 = ignore CRC (debug mode).
- TIMEOUT_CYC, 100000, idle cycles inside a frame before abort; must be >= 2.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  DW  incoming stream word
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  decoder accepts the word; a transfer occurs when rx_valid & rx_ready
- q  out  DW  forwarded payload word, shared by all channels
- q_last  out  1  current q is the final word of the packet
- valid_bus  out  N_CH  one-hot; bit DEST high while q is valid
- out_ready  in  N_CH  per-channel sink ready
- crc_err  out  1  one-cycle pulse: packet dropped, bad CRC
- dest_err  out  1  one-cycle pulse: packet dropped, DEST >= N_CH
- timeout_err  out  1  one-cycle pulse: frame aborted by timeout
- err_cnt  out  16  saturating count of all three error events

Behaviour:
- Reset (async, n_rst low): state IDLE, buffer flushed, counters 0. All outputs 0 except rx_ready = 1.
- States: IDLE, DEST, LEN, DATA, CRC, FWD.
  - IDLE: accepted word == PREFIX -> DEST; any other word is discarded.
  - DEST: latch dest; crc_acc = word -> LEN.
  - LEN: latch len; crc_acc += word. If len == 0 -> CRC, else -> DATA.
  - DATA: write word to buffer; crc_acc += word; count words. After the len-th word -> CRC.
  - CRC, when the word is accepted:
    - If CRC_EN and word != crc_acc: crc_err pulse, flush, -> IDLE.
    - Else if dest >= N_CH: dest_err pulse, flush, -> IDLE.
    - Else if len == 0: -> IDLE with nothing forwarded.
    - Else: -> FWD.
  - If a packet has both a bad CRC and a bad DEST, only crc_err pulses.
- CRC arithmetic: sum of DEST, LEN and all payload words, modulo 2^DW. The carry is discarded.
- rx_ready is 1 in every state except FWD, where it is 0. Input is fully stalled while a packet is being forwarded.
- FWD:
  - Buffer is read in order. valid_bus = 1 << dest while a word is presented; q holds its value until out_ready[dest] is high.
  - The next word appears on the cycle after the handshake. The first word is valid the cycle after the CRC word is accepted.
  - q_last is high with the len-th word. Its handshake -> IDLE; valid_bus = 0 the next cycle.
  - out_ready bits other than dest are ignored. valid_bus never has more than one bit set.
- Timeout:
  - The counter increments each cycle in DEST/LEN/DATA/CRC with no accepted word.
  - It clears on any accepted word and is held at 0 in IDLE and FWD.
  - On reaching TIMEOUT_CYC-1: synchronous abort, flush, timeout_err pulse, -> IDLE.
  - A word accepted in that same cycle is discarded. FWD never times out.
- Flush empties the buffer in one cycle; the next packet can start on the following cycle.
- err_cnt increments by 1 per error pulse and saturates at 16'hFFFF. Only reset clears it.
- A PREFIX value inside DEST/LEN/DATA/CRC is treated as ordinary data; no resynchronisation mid-frame.
- Reset mid-packet or mid-forward: immediate return to the reset state. A partial packet is never forwarded.

Test Plan:
- N_CH=8: send AA 03 02 11 22 38 with out_ready=all 1 -> valid_bus=8'h08 for 2 cycles; q=11 then 22; q_last with 22; no error pulses.
- Same frame with CRC byte 39, CRC_EN=1 -> nothing forwarded, crc_err pulse, err_cnt=1. Repeat with CRC_EN=0 -> forwarded as in scenario 1.
- AA 09 01 55 5F (correct CRC, dest 9 >= N_CH) -> dest_err pulse, valid_bus stays 0, err_cnt increments.
- Forwarding with out_ready[3] toggling 0/1 each cycle -> q stable while not ready, each word forwarded exactly once. rx_ready=0 throughout FWD; rx words offered during FWD are not consumed.
- AA 02 05 01 then silence for TIMEOUT_CYC cycles -> timeout_err pulse, state IDLE. The next valid frame AA 02 01 7E 81 forwards 7E on valid_bus bit 2.
- Zero-length frame AA 04 00 04 -> no valid_bus activity, no error. Leading junk 00 FF before AA -> ignored, with no error pulse.
